lcd_read_fsm: RTL and testbench

- Read-side counterpart of the LCD write-timing FSM.
- Performs one 4-bit-mode read cycle on the character LCD (RW=1): busy-flag/address read (RS=0) or DDRAM/CGRAM data read (RS=1). Assembles the two nibbles into a byte.
- Optionally polls the busy flag until it clears, so the command sequencer can replace fixed waits with BF polling.
- Sits beside the write-timing FSM; the sequencer arbitrates LCD pin ownership between the two.

---
 rtl/lcd_read_fsm.sv | 139 +++++++++++++
 tb/tb_lcd_read_fsm.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_read_fsm.sv
// lcd_read_fsm: one 4-bit-mode read cycle on a character LCD.
// Reads the busy flag/address (rs_sel=0) or DDRAM/CGRAM data (rs_sel=1).
// Two E pulses fetch the upper and lower nibbles, which are assembled into a byte.
// In poll mode the busy-flag read repeats until BF clears or MAX_POLLS reads are done.
// All pin outputs are registered and change together with the state register.
module lcd_read_fsm #(
  parameter int TICK      = 64,
  parameter int MAX_POLLS = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs_sel,
  input  logic       poll,
  input  logic [3:0] lcd_db_in,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_db_oe,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       busy,
  output logic       timeout
);

  localparam int CW = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int PW = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(MAX_POLLS - 1);

  typedef enum logic [2:0] {IDLE, SETUP, EH1, EL1, EH2, EL2, REL} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] poll_cnt;
  logic          rs_q;
  logic          poll_q;
  logic [7:0]    cap;
  logic          last;
  logic          again;

  // Final cycle of the current state's TICK-long slot.
  assign last  = (cnt == CNT_LAST);
  // Repeat the BF read only while BF is still set and the poll budget remains.
  // poll_q is already forced to 0 for data reads.
  assign again = poll_q & cap[7] & (poll_cnt < POLL_LAST);

  // Read sequencer: state, slot counter, nibble capture and registered pin outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      poll_cnt  <= '0;
      rs_q      <= 1'b0;
      poll_q    <= 1'b0;
      cap       <= 8'h00;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_rw    <= 1'b0;
      lcd_db_oe <= 1'b1;
      data_out  <= 8'h00;
      valid     <= 1'b0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (state == IDLE) begin
        cnt <= '0;
        if (start) begin
          state     <= SETUP;
          rs_q      <= rs_sel;
          poll_q    <= poll & ~rs_sel;
          busy      <= 1'b1;
          timeout   <= 1'b0;
          lcd_rs    <= rs_sel;
          lcd_rw    <= 1'b1;
          lcd_db_oe <= 1'b0;
        end
      end else if (!last) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        case (state)
          SETUP: begin
            state <= EH1;
            lcd_e <= 1'b1;
          end
          EH1: begin
            state    <= EL1;
            lcd_e    <= 1'b0;
            cap[7:4] <= lcd_db_in;
          end
          EL1: begin
            state <= EH2;
            lcd_e <= 1'b1;
          end
          EH2: begin
            state    <= EL2;
            lcd_e    <= 1'b0;
            cap[3:0] <= lcd_db_in;
          end
          EL2: begin
            if (again) begin
              // Back-to-back BF read: RW stays high and the pads stay released.
              state    <= SETUP;
              poll_cnt <= poll_cnt + 1'b1;
            end else begin
              state  <= REL;
              lcd_rw <= 1'b0;
            end
          end
          REL: begin
            state     <= IDLE;
            data_out  <= cap;
            valid     <= 1'b1;
            // Reaching REL with BF still set in poll mode means the budget ran out.
            timeout   <= poll_q & ~rs_q & cap[7];
            poll_cnt  <= '0;
            lcd_db_oe <= 1'b1;
            lcd_rs    <= 1'b0;
            busy      <= 1'b0;
          end
          default: begin
            state     <= IDLE;
            lcd_e     <= 1'b0;
            lcd_rw    <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_db_oe <= 1'b1;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  // The FPGA must never drive DB while the LCD may be driving it.
  bus_contention: assert property (@(posedge clk) disable iff (rst) lcd_rw |-> !lcd_db_oe);

endmodule

// File: tb/tb_lcd_read_fsm.sv
// tb_lcd_read_fsm: directed and randomised read/poll transactions checked
// against a transaction-level LCD model, plus a pin-timing monitor.
module tb_lcd_read_fsm;
  localparam int TICK = 64;
  localparam int MAXP = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       rs_sel;
  logic       poll;
  logic [3:0] lcd_db_in;
  logic       lcd_e, lcd_rs, lcd_rw, lcd_db_oe;
  logic [7:0] data_out;
  logic       valid, busy, timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int epulses = 0;
  bit cur_rs = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic       last_to = 1'b0;
  logic [7:0] rsp [MAXP];
  logic [3:0] nib_q [$];

  lcd_read_fsm #(.TICK(TICK), .MAX_POLLS(MAXP)) dut (
    .clk(clk), .rst(rst), .start(start), .rs_sel(rs_sel), .poll(poll),
    .lcd_db_in(lcd_db_in), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_db_oe(lcd_db_oe), .data_out(data_out), .valid(valid), .busy(busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // LCD pad model: present the next queued nibble while E is high, junk otherwise.
  initial begin
    forever begin
      @(lcd_e);
      if (lcd_e && nib_q.size() > 0) lcd_db_in = nib_q.pop_front();
      else lcd_db_in = 4'($urandom);
    end
  end

  // Pin timing monitor.
  initial begin
    logic p_e, p_rw, p_oe;
    int t_rwr, t_er, t_ef, t_rwf;
    p_e = 1'b0; p_rw = 1'b0; p_oe = 1'b1;
    t_rwr = 0; t_er = 0; t_ef = 0; t_rwf = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        p_e = 1'b0; p_rw = 1'b0; p_oe = 1'b1;
      end else begin
        if (lcd_rw) chk("oe_while_rw", lcd_db_oe, 0);
        if (lcd_rw && !p_rw) t_rwr = cyc;
        if (!lcd_rw && p_rw) begin
          chk("rw_hold_after_e", cyc - t_ef, TICK);
          t_rwf = cyc;
        end
        if (lcd_e && !p_e) begin
          chk("rw_setup_ok", 32'((cyc - t_rwr) >= TICK), 1);
          chk("rs_during_e", lcd_rs, cur_rs);
          chk("rw_during_e", lcd_rw, 1);
          t_er = cyc;
          epulses++;
        end
        if (!lcd_e && p_e) begin
          chk("e_width", cyc - t_er, TICK);
          t_ef = cyc;
        end
        if (lcd_db_oe && !p_oe) chk("oe_gap_ok", 32'((cyc - t_rwf) >= TICK), 1);
        p_e = lcd_e; p_rw = lcd_rw; p_oe = lcd_db_oe;
      end
    end
  end

  // One transaction against the LCD model held in rsp[] (one byte per read cycle).
  task automatic do_read(input bit rs, input bit pl, input bit inject);
    int n, s, e0;
    logic [7:0] eb;
    bit et, got;
    // Model: poll mode keeps reading while BF=1, up to MAXP reads total.
    n = 1;
    if (pl && !rs) while (n < MAXP && rsp[n-1][7]) n++;
    eb = rsp[n-1];
    et = pl && !rs && rsp[n-1][7];
    nib_q.delete();
    for (int i = 0; i < MAXP; i++) begin
      nib_q.push_back(rsp[i][7:4]);
      nib_q.push_back(rsp[i][3:0]);
    end
    cur_rs = rs;
    @(negedge clk);
    chk("timeout_hold", timeout, last_to);
    start = 1'b1; rs_sel = rs; poll = pl;
    @(negedge clk);
    start = 1'b0; rs_sel = 1'($urandom); poll = 1'($urandom);
    s = cyc;
    e0 = epulses;
    chk("busy_rise", busy, 1);
    chk("timeout_clr", timeout, 0);
    chk("rw_rise", lcd_rw, 1);
    chk("oe_fall", lcd_db_oe, 0);
    chk("rs_latched", lcd_rs, rs);
    got = 1'b0;
    for (int k = 0; k < 6*TICK + 5*TICK*MAXP + 20; k++) begin
      @(negedge clk);
      start = inject && (cyc - s == 3*TICK + 5);
      if (valid) begin
        got = 1'b1;
        break;
      end
      chk("data_hold", data_out, last_data);
    end
    start = 1'b0;
    chk("valid_seen", got, 1);
    if (got) begin
      chk("latency", cyc - s, 6*TICK + 5*TICK*(n-1));
      chk("data_out", data_out, eb);
      chk("timeout", timeout, et);
      chk("e_pulses", epulses - e0, 2*n);
      chk("busy_fall", busy, 0);
      chk("oe_back", lcd_db_oe, 1);
      chk("rs_idle", lcd_rs, 0);
      last_data = eb;
      last_to = et;
      @(negedge clk);
      chk("valid_one_cycle", valid, 0);
    end
  endtask

  initial begin
    int vcount, e0;
    rst = 1'b1; start = 1'b0; rs_sel = 1'b0; poll = 1'b0; lcd_db_in = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("rst_e", lcd_e, 0);
    chk("rst_rw", lcd_rw, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_oe", lcd_db_oe, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_timeout", timeout, 0);

    // Data read.
    rsp = '{8'hA5, 8'h11, 8'h22, 8'h33};
    do_read(1'b1, 1'b0, 1'b0);
    // Poll request with rs_sel=1 is a single data read.
    rsp = '{8'hC4, 8'h80, 8'h80, 8'h80};
    do_read(1'b1, 1'b1, 1'b0);
    // BF busy for three reads, then clear.
    rsp = '{8'h83, 8'h83, 8'h83, 8'h03};
    do_read(1'b0, 1'b1, 1'b0);
    // BF stuck: budget runs out, timeout set.
    rsp = '{8'h91, 8'h91, 8'h91, 8'h91};
    do_read(1'b0, 1'b1, 1'b0);
    // Next start clears timeout; a start pulse during EH2 is ignored.
    rsp = '{8'h3C, 8'h00, 8'h00, 8'h00};
    do_read(1'b1, 1'b0, 1'b1);
    e0 = epulses;
    repeat (2*TICK) @(negedge clk);
    chk("ignored_start_busy", busy, 0);
    chk("ignored_start_pulses", epulses - e0, 0);

    // Async reset in the middle of EL1.
    rsp = '{8'h5A, 8'h00, 8'h00, 8'h00};
    nib_q.delete();
    nib_q.push_back(4'h5); nib_q.push_back(4'hA);
    cur_rs = 1'b0;
    @(negedge clk);
    start = 1'b1; rs_sel = 1'b0; poll = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2*TICK + 9) @(negedge clk);
    chk("pre_rst_rw", lcd_rw, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_e", lcd_e, 0);
    chk("arst_rw", lcd_rw, 0);
    chk("arst_rs", lcd_rs, 0);
    chk("arst_oe", lcd_db_oe, 1);
    chk("arst_busy", busy, 0);
    chk("arst_valid", valid, 0);
    chk("arst_data", data_out, 8'h00);
    chk("arst_timeout", timeout, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    last_data = 8'h00;
    last_to = 1'b0;
    vcount = 0;
    e0 = epulses;
    for (int k = 0; k < 8*TICK; k++) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    chk("no_valid_after_rst", vcount, 0);
    chk("idle_after_rst", busy, 0);
    chk("no_e_after_rst", epulses - e0, 0);

    // Randomised transactions.
    repeat (20) begin
      bit rs, pl;
      rs = 1'($urandom);
      pl = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < MAXP; i++) rsp[i] = {($urandom_range(0, 2) != 0), 7'($urandom)};
      repeat ($urandom_range(0, 20)) @(negedge clk);
      do_read(rs, pl, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
